// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes, error codes.
package rv32_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned ERR_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [FMT_W-1:0] {
        FMT_U       = 3'd0,
        FMT_J       = 3'd1,
        FMT_B       = 3'd2,
        FMT_I       = 3'd3,
        FMT_S       = 3'd4,
        FMT_R       = 3'd5,
        FMT_INVALID = 3'd6
    } fmt_e;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [ERR_W-1:0] ERR_NONE   = 2'd0;
    localparam logic [ERR_W-1:0] ERR_OPCODE = 2'd1;
    localparam logic [ERR_W-1:0] ERR_RANGE  = 2'd2;
    localparam logic [ERR_W-1:0] ERR_ALIGN  = 2'd3;

    // Decoded instruction fields travelling through the encoder pipeline.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } instr_fields_t;

    // Major opcode to instruction format; same mapping the decoder uses.
    function automatic fmt_e fmt_of(input logic [OPC_W-1:0] opc);
        fmt_e f;
        case (opc)
            OPC_OP:                                   f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                f = FMT_S;
            OPC_LUI, OPC_AUIPC:                       f = FMT_U;
            OPC_BRANCH:                               f = FMT_B;
            OPC_JAL:                                  f = FMT_J;
            default:                                  f = FMT_INVALID;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: places register indices, functs and immediate slices per format.
module instr_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic        i_shift,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr_c
);

    // Bit 0 of B/J offsets is implied by alignment and never encoded.
    logic w_unused;
    assign w_unused = i_imm[0];

    // Format-driven field placement.
    always_comb begin
        o_instr_c = '0;
        case (i_fmt)
            FMT_R: o_instr_c = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                if (i_shift) begin
                    o_instr_c = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                end else begin
                    o_instr_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                end
            end
            FMT_S: o_instr_c = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_U: o_instr_c = {i_imm[31:12], i_rd, i_opcode};
            FMT_B: o_instr_c = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                i_imm[4:1], i_imm[11], i_opcode};
            FMT_J: o_instr_c = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                                i_rd, i_opcode};
            default: o_instr_c = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder: stage 1 classifies and range-checks, stage 2 packs and holds the output.
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [1:0]       out_err_code,
    output logic [IDX_W-1:0] out_idx,
    output logic [7:0]       err_count
);

    fmt_e             w_fmt;
    logic             w_shift;
    logic [ERR_W-1:0] w_err_code;
    instr_fields_t    w_fields;
    logic             w_hi11_ok;
    logic             w_hi12_ok;
    logic             w_hi20_ok;

    logic             r_s1_valid;
    fmt_e             r_s1_fmt;
    logic             r_s1_shift;
    logic [ERR_W-1:0] r_s1_err;
    instr_fields_t    r_s1_fields;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_instr;
    logic             r_out_err;
    logic [ERR_W-1:0] r_out_err_code;
    logic [IDX_W-1:0] r_out_idx;
    logic [CNT_W-1:0] r_err_count;

    logic             w_s2_ready;
    logic             w_s1_load;
    logic             w_out_fire;
    logic [XLEN-1:0]  w_pack_instr;

    assign w_s2_ready = !r_out_valid || out_ready;
    assign in_ready   = !flush && (!r_s1_valid || w_s2_ready);
    assign w_s1_load  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Classify the incoming opcode and check the immediate against what the format can hold.
    always_comb begin
        w_fmt      = fmt_of(in_opcode);
        w_shift    = (in_opcode == OPC_OP_IMM) &&
                     ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
        w_hi11_ok  = (in_imm[31:11] == '0) || (&in_imm[31:11]);
        w_hi12_ok  = (in_imm[31:12] == '0) || (&in_imm[31:12]);
        w_hi20_ok  = (in_imm[31:20] == '0) || (&in_imm[31:20]);
        w_err_code = ERR_NONE;
        case (w_fmt)
            FMT_INVALID: w_err_code = ERR_OPCODE;
            FMT_I: begin
                if (w_shift) begin
                    if (in_imm[31:5] != '0) w_err_code = ERR_RANGE;
                end else if (!w_hi11_ok) begin
                    w_err_code = ERR_RANGE;
                end
            end
            FMT_S: if (!w_hi11_ok) w_err_code = ERR_RANGE;
            FMT_U: if (in_imm[11:0] != '0) w_err_code = ERR_RANGE;
            FMT_B: begin
                if (in_imm[0])       w_err_code = ERR_ALIGN;
                else if (!w_hi12_ok) w_err_code = ERR_RANGE;
            end
            FMT_J: begin
                if (in_imm[0])       w_err_code = ERR_ALIGN;
                else if (!w_hi20_ok) w_err_code = ERR_RANGE;
            end
            default: w_err_code = ERR_NONE;
        endcase
    end

    // Bundle the raw input fields for stage 1.
    always_comb begin
        w_fields        = '0;
        w_fields.opcode = in_opcode;
        w_fields.funct3 = in_funct3;
        w_fields.funct7 = in_funct7;
        w_fields.rd     = in_rd;
        w_fields.rs1    = in_rs1;
        w_fields.rs2    = in_rs2;
        w_fields.imm    = in_imm;
    end

    // Stage 1 register: loads when empty or when its word moves to stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= FMT_INVALID;
            r_s1_shift  <= 1'b0;
            r_s1_err    <= ERR_NONE;
            r_s1_fields <= '0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid  <= 1'b1;
            r_s1_fmt    <= w_fmt;
            r_s1_shift  <= w_shift;
            r_s1_err    <= w_err_code;
            r_s1_fields <= w_fields;
        end else if (w_s2_ready) begin
            r_s1_valid  <= 1'b0;
        end
    end

    instr_pack u_pack (
        .i_fmt     (r_s1_fmt),
        .i_shift   (r_s1_shift),
        .i_opcode  (r_s1_fields.opcode),
        .i_funct3  (r_s1_fields.funct3),
        .i_funct7  (r_s1_fields.funct7),
        .i_rd      (r_s1_fields.rd),
        .i_rs1     (r_s1_fields.rs1),
        .i_rs2     (r_s1_fields.rs2),
        .i_imm     (r_s1_fields.imm),
        .o_instr_c (w_pack_instr)
    );

    // Stage 2 output register: errored words are delivered with a zero payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_err      <= 1'b0;
            r_out_err_code <= ERR_NONE;
        end else if (flush) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_err      <= 1'b0;
            r_out_err_code <= ERR_NONE;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr    <= (r_s1_err != ERR_NONE) ? '0 : w_pack_instr;
                r_out_err      <= (r_s1_err != ERR_NONE);
                r_out_err_code <= r_s1_err;
            end
        end
    end

    // Delivered-word index and saturating error counter advance on each output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_idx   <= '0;
            r_err_count <= '0;
        end else if (w_out_fire) begin
            r_out_idx <= r_out_idx + IDX_W'(1);
            if (r_out_err && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_err      = r_out_err;
    assign out_err_code = r_out_err_code;
    assign out_idx      = r_out_idx;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;

    localparam int unsigned IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [6:0]       in_opcode, in_funct7;
    logic [2:0]       in_funct3;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [31:0]      in_imm, out_instr;
    logic [1:0]       out_err_code;
    logic [IDX_W-1:0] out_idx;
    logic [7:0]       err_count;

    always #5 clk = ~clk;

    instr_encoder #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .out_err_code(out_err_code),
        .out_idx(out_idx), .err_count(err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        q[$];
    exp_t        log_q[$];
    int          log_idx[$];
    int          log_cyc[$];
    int          ncheck = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    int          exp_idx = 0;
    int          exp_err = 0;
    bit          acc_flag;
    bit          prev_stall = 0;
    logic [31:0] st_instr;
    logic        st_err;
    logic [1:0]  st_code;
    int          st_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from the ISA field layout with plain arithmetic.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] imm);
        exp_t        e;
        longint      s;
        int unsigned o, d, a, b, f, g, u, w;
        bit          bad, mis, rng;
        s = longint'($signed(imm));
        o = int'(op); d = int'(rd); a = int'(rs1); b = int'(rs2);
        f = int'(f3); g = int'(f7); u = imm;
        bad = 0; mis = 0; rng = 0; w = 0;
        case (op)
            7'h33: w = (g << 25) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
            7'h13, 7'h03, 7'h67, 7'h73: begin
                if (op == 7'h13 && (f == 1 || f == 5)) begin
                    rng = u > 31;
                    w = (g << 25) | (u << 20) | (a << 15) | (f << 12) | (d << 7) | o;
                end else begin
                    rng = (s < -2048) || (s > 2047);
                    w = ((u % 4096) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
                end
            end
            7'h23: begin
                rng = (s < -2048) || (s > 2047);
                w = (((u / 32) % 128) << 25) | (b << 20) | (a << 15) | (f << 12) | ((u % 32) << 7) | o;
            end
            7'h37, 7'h17: begin
                rng = (u % 4096) != 0;
                w = ((u / 4096) * 4096) | (d << 7) | o;
            end
            7'h63: begin
                mis = (u % 2) != 0;
                rng = (s < -4096) || (s > 4095);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (b << 20) | (a << 15) |
                    (f << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | o;
            end
            7'h6F: begin
                mis = (u % 2) != 0;
                rng = (s < -1048576) || (s > 1048575);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
                    (((u >> 12) & 255) << 12) | (d << 7) | o;
            end
            default: bad = 1;
        endcase
        e.code  = bad ? 2'd1 : (mis ? 2'd3 : (rng ? 2'd2 : 2'd0));
        e.err   = (e.code != 2'd0);
        e.instr = e.err ? 32'h0 : w;
        return e;
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        in_valid = 1'b1;
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // One clock: sample handshakes at the falling edge, update the scoreboard, advance.
    task automatic tick();
        @(negedge clk);
        acc_flag = 1'b0;
        if (rst) begin
            q.delete();
            exp_idx = 0;
            exp_err = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_instr", out_instr, st_instr);
                chk("stall_err",   32'(out_err), 32'(st_err));
                chk("stall_code",  32'(out_err_code), 32'(st_code));
                chk("stall_idx",   32'(out_idx), 32'(st_idx));
            end
            chk("err_count", 32'(err_count), 32'(exp_err));
            if (flush) chk("flush_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_err", 32'(out_err), 32'(e.err));
                    chk("out_err_code", 32'(out_err_code), 32'(e.code));
                    chk("out_idx", 32'(out_idx), 32'(exp_idx));
                    if (e.err && exp_err < 255) exp_err++;
                end
                log_q.push_back('{out_instr, out_err, out_err_code});
                log_idx.push_back(int'(out_idx));
                log_cyc.push_back(cyc);
                exp_idx = (exp_idx + 1) % (1 << IDX_W);
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                acc_flag = 1'b1;
                q.push_back(model(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm));
                chk("occupancy", 32'(q.size() <= 2), 32'd1);
            end
            prev_stall = out_valid && !out_ready && !flush;
            st_instr = out_instr; st_err = out_err; st_code = out_err_code; st_idx = int'(out_idx);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_instr"}, out_instr, 32'd0);
        chk({tag, "_err"},   32'(out_err), 32'd0);
        chk({tag, "_code"},  32'(out_err_code), 32'd0);
        chk({tag, "_idx"},   32'(out_idx), 32'd0);
        chk({tag, "_cnt"},   32'(err_count), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        log_q.delete(); log_idx.delete(); log_cyc.delete();
    endtask

    task automatic drain(input int maxc);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < maxc && (q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bnd[17];
        logic [6:0] opl[11];
        bnd = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097, 1048575, 1048576,
                -1048576, -1048577, 31, 32, 0, 1, 32'h12345000};
        opl = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h7F};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0);
        in_valid = 1'b0;

        // Reset state
        do_reset();
        chk_reset_vals("reset");

        // addi x1,x0,5 with two-cycle latency
        set_in(7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        chk("addi_accept", 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
        chk("addi_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("addi_lat2_valid", 32'(out_valid), 32'd1);
        chk("addi_instr", out_instr, 32'h00500093);
        chk("addi_err", 32'(out_err), 32'd0);
        drain(10);

        // Back-to-back stream
        do_reset();
        set_in(7'h33, 3'h0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);         tick();
        set_in(7'h37, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);  tick();
        set_in(7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);  tick();
        set_in(7'h6F, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd8);         tick();
        drain(10);
        chk("stream_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("stream_add", log_q[0].instr, 32'h002081B3);
            chk("stream_lui", log_q[1].instr, 32'h123452B7);
            chk("stream_beq", log_q[2].instr, 32'hFE208EE3);
            chk("stream_jal", log_q[3].instr, 32'h0080006F);
            for (int i = 0; i < 4; i++) chk("stream_idx", 32'(log_idx[i]), 32'(i));
            for (int i = 1; i < 4; i++) chk("stream_rate", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
        end

        // Error words
        do_reset();
        set_in(7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);  tick();
        set_in(7'h6F, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd3);     tick();
        set_in(7'h7F, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0);     tick();
        drain(10);
        chk("err_words", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("err_range_code", 32'(log_q[0].code), 32'd2);
            chk("err_range_instr", log_q[0].instr, 32'd0);
            chk("err_align_code", 32'(log_q[1].code), 32'd3);
            chk("err_opc_code", 32'(log_q[2].code), 32'd1);
        end
        tick();
        chk("err_count_3", 32'(err_count), 32'd3);

        // Backpressure: two accepts, then stall
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(7'h13, 3'h0, 7'h0, 5'(k + 1), 5'd0, 5'd0, 32'(k * 3));
            tick();
            if (acc_flag) k++;
        end
        chk("bp_accepts", 32'(k), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && k < 3; i++) begin
            set_in(7'h13, 3'h0, 7'h0, 5'(k + 1), 5'd0, 5'd0, 32'(k * 3));
            tick();
            if (acc_flag) k++;
        end
        chk("bp_third", 32'(k), 32'd3);
        drain(10);
        chk("bp_delivered", 32'(log_q.size()), 32'd3);

        // Flush with two words in flight
        do_reset();
        set_in(7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd1); tick();
        drain(10);
        out_ready = 1'b0;
        set_in(7'h13, 3'h0, 7'h0, 5'd2, 5'd0, 5'd0, 32'd2); tick();
        set_in(7'h13, 3'h0, 7'h0, 5'd3, 5'd0, 5'd0, 32'd3); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("flush_valid", 32'(out_valid), 32'd0);
            chk("flush_idx", 32'(out_idx), 32'd1);
            tick();
        end

        // Reset mid-stream
        out_ready = 1'b1;
        set_in(7'h33, 3'h0, 7'h0, 5'd4, 5'd5, 5'd6, 32'd0);  tick();
        set_in(7'h7F, 3'h0, 7'h0, 5'd4, 5'd5, 5'd6, 32'd0);  tick();
        set_in(7'h7F, 3'h0, 7'h0, 5'd4, 5'd5, 5'd6, 32'd0);  tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_vals("midrst");

        // Index wrap with 5 words
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(7'h13, 3'h0, 7'h0, 5'(i), 5'd0, 5'd0, 32'(i));
            tick();
        end
        drain(10);
        chk("wrap_count", 32'(log_idx.size()), 32'd5);
        if (log_idx.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("wrap_idx", 32'(log_idx[i]), 32'(i % 4));
        end

        // Error counter saturation
        do_reset();
        set_in(7'h7F, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 262; i++) tick();
        drain(10);
        tick();
        chk("err_sat", 32'(err_count), 32'd255);

        // Randomized traffic with backpressure and occasional flush
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 2))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = 32'(bnd[$urandom_range(0, 16)]);
            endcase
            set_in(($urandom_range(0, 9) == 0) ? 7'($urandom) : opl[$urandom_range(0, 10)],
                   3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            if (flush) out_ready = 1'b0;
            tick();
        end
        flush = 1'b0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
